// File: rtl/present_crypt_core.sv
// present_crypt_core -- iterative PRESENT block cipher, one round per clock.
//
// 64-bit block with an 80- or 128-bit key. Each request picks encrypt or
// decrypt. Decryption must start from the last round key, so a cache miss
// first runs a KEYGEN pass that walks the key schedule forward. The result is
// kept in a one-entry cache so that a repeated decrypt key skips that pass.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   req    request level, sampled only in IDLE (four-phase with ack)
//   dec    0 = encrypt, 1 = decrypt; captured with req
//   K      key (KEY_W bits); captured with req
//   M      input block; captured with req
//   C      result block; registered, held until the next result or reset
//   ack    result valid; held in DONE until req drops
//   busy   high while in KEYGEN or RUN
module present_crypt_core #(
  parameter int KEY_W  = 80,
  parameter int ROUNDS = 31
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic             dec,
  input  logic [KEY_W-1:0] K,
  input  logic [63:0]      M,
  output logic [63:0]      C,
  output logic             ack,
  output logic             busy
);

  if (KEY_W != 80 && KEY_W != 128) begin : g_bad_key_w
    $error("present_crypt_core: KEY_W must be 80 or 128");
  end

  localparam int RND_W  = $clog2(ROUNDS + 2);
  // Lowest key bit that takes the round-counter XOR.
  localparam int XOR_LO = (KEY_W == 128) ? 62 : 15;

  typedef enum logic [1:0] {IDLE, KEYGEN, RUN, DONE} state_t;

  state_t             state;
  logic [63:0]        blk;
  logic [KEY_W-1:0]   key;
  logic [KEY_W-1:0]   cached_key;
  logic [KEY_W-1:0]   cached_final;
  logic               cache_valid;
  logic               dec_q;
  logic [RND_W-1:0]   rnd;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
      4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
      4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
      4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  default: sbox = 4'h2;
    endcase
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    case (x)
      4'h0: inv_sbox = 4'h5;  4'h1: inv_sbox = 4'hE;  4'h2: inv_sbox = 4'hF;  4'h3: inv_sbox = 4'h8;
      4'h4: inv_sbox = 4'hC;  4'h5: inv_sbox = 4'h1;  4'h6: inv_sbox = 4'h2;  4'h7: inv_sbox = 4'hD;
      4'h8: inv_sbox = 4'hB;  4'h9: inv_sbox = 4'h4;  4'hA: inv_sbox = 4'h6;  4'hB: inv_sbox = 4'h3;
      4'hC: inv_sbox = 4'h0;  4'hD: inv_sbox = 4'h7;  4'hE: inv_sbox = 4'h9;  default: inv_sbox = 4'hA;
    endcase
  endfunction

  // NOTE: every bit of the local result is written before it is returned, so
  // the combinational logic built from these functions cannot infer a latch.
  function automatic logic [63:0] s_layer(input logic [63:0] x, input logic inverse);
    logic [63:0] y;
    for (int n = 0; n < 16; n++)
      y[4*n +: 4] = inverse ? inv_sbox(x[4*n +: 4]) : sbox(x[4*n +: 4]);
    return y;
  endfunction

  // Bit i moves to 16*(i mod 4) + i/4.
  function automatic logic [63:0] p_layer(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[(i % 4) * 16 + i / 4] = x[i];
    return y;
  endfunction

  function automatic logic [63:0] inv_p_layer(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[i] = x[(i % 4) * 16 + i / 4];
    return y;
  endfunction

  function automatic logic [KEY_W-1:0] key_fwd(input logic [KEY_W-1:0] k, input logic [4:0] ctr);
    logic [KEY_W-1:0] r;
    r = {k[KEY_W-62:0], k[KEY_W-1:KEY_W-61]};
    r[KEY_W-1 -: 4] = sbox(r[KEY_W-1 -: 4]);
    if (KEY_W == 128) r[KEY_W-5 -: 4] = sbox(r[KEY_W-5 -: 4]);
    r[XOR_LO +: 5] = r[XOR_LO +: 5] ^ ctr;
    return r;
  endfunction

  function automatic logic [KEY_W-1:0] key_inv(input logic [KEY_W-1:0] k, input logic [4:0] ctr);
    logic [KEY_W-1:0] r;
    r = k;
    r[XOR_LO +: 5] = r[XOR_LO +: 5] ^ ctr;
    r[KEY_W-1 -: 4] = inv_sbox(r[KEY_W-1 -: 4]);
    if (KEY_W == 128) r[KEY_W-5 -: 4] = inv_sbox(r[KEY_W-5 -: 4]);
    return {r[60:0], r[KEY_W-1:61]};
  endfunction

  logic [KEY_W-1:0] key_next_fwd;
  logic [KEY_W-1:0] key_next_inv;
  logic [63:0]      rk;
  logic [63:0]      enc_blk;
  logic [63:0]      dec_blk;

  assign rk           = key[KEY_W-1 -: 64];
  assign key_next_fwd = key_fwd(key, 5'(rnd));
  assign key_next_inv = key_inv(key, 5'(rnd));
  assign enc_blk      = p_layer(s_layer(blk ^ rk, 1'b0));
  assign dec_blk      = s_layer(inv_p_layer(blk ^ rk), 1'b1);

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the values from before the edge, whatever the statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the datapath and cache registers are reset along with the FSM;
      // a cleared cache_valid alone is what guarantees no stale hit.
      state        <= IDLE;
      C            <= '0;
      ack          <= 1'b0;
      busy         <= 1'b0;
      rnd          <= '0;
      cache_valid  <= 1'b0;
      cached_key   <= '0;
      cached_final <= '0;
      blk          <= '0;
      key          <= '0;
      dec_q        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            blk   <= M;
            dec_q <= dec;
            busy  <= 1'b1;
            if (!dec) begin
              key   <= K;
              rnd   <= RND_W'(1);
              state <= RUN;
            end else if (cache_valid && K == cached_key) begin
              key   <= cached_final;
              rnd   <= RND_W'(ROUNDS);
              state <= RUN;
            end else begin
              // The key tag is written now; the entry only becomes valid
              // once KEYGEN has produced the matching final key.
              key         <= K;
              cached_key  <= K;
              cache_valid <= 1'b0;
              rnd         <= RND_W'(1);
              state       <= KEYGEN;
            end
          end
        end

        KEYGEN: begin
          key <= key_next_fwd;
          if (rnd == RND_W'(ROUNDS)) begin
            cached_final <= key_next_fwd;
            cache_valid  <= 1'b1;
            state        <= RUN;
          end else begin
            rnd <= rnd + 1'b1;
          end
        end

        RUN: begin
          if (!dec_q) begin
            blk <= enc_blk;
            key <= key_next_fwd;
            if (rnd == RND_W'(ROUNDS)) begin
              C     <= enc_blk ^ key_next_fwd[KEY_W-1 -: 64];
              busy  <= 1'b0;
              state <= DONE;
            end else begin
              rnd <= rnd + 1'b1;
            end
          end else begin
            blk <= dec_blk;
            key <= key_next_inv;
            if (rnd == RND_W'(1)) begin
              C     <= dec_blk ^ key_next_inv[KEY_W-1 -: 64];
              busy  <= 1'b0;
              state <= DONE;
            end else begin
              rnd <= rnd - 1'b1;
            end
          end
        end

        DONE: begin
          // C is loaded on the entry edge; ack follows one edge later and is
          // then held until req is seen low.
          if (!ack) begin
            ack <= 1'b1;
          end else if (!req) begin
            ack   <= 1'b0;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_present_crypt_core.sv
// tb_present_crypt_core -- self-checking bench for present_crypt_core.
// Drives an 80-bit and a 128-bit instance from a shared clock and reset and
// compares results and handshake timing against a textbook PRESENT model
// (precomputed round-key table) plus a model of the one-entry decrypt cache.
module tb_present_crypt_core;

  localparam int R     = 31;
  localparam int LIMIT = 3 * R + 10;
  localparam logic [3:0] SBOX [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                       4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req80, req128, dec;
  logic [79:0]  k80;
  logic [127:0] k128;
  logic [63:0]  m;
  logic [63:0]  c80, c128;
  logic         ack80, ack128, busy80, busy128;

  int n_checks = 0;
  int n_fail   = 0;

  // Cache model, indexed by instance (0 = 80-bit, 1 = 128-bit).
  bit           cv [2];
  logic [127:0] ck [2];

  always #5 clk = ~clk;

  present_crypt_core #(.KEY_W(80), .ROUNDS(R)) dut80 (
    .clk(clk), .rst_n(rst_n), .req(req80), .dec(dec), .K(k80), .M(m),
    .C(c80), .ack(ack80), .busy(busy80));

  present_crypt_core #(.KEY_W(128), .ROUNDS(R)) dut128 (
    .clk(clk), .rst_n(rst_n), .req(req128), .dec(dec), .K(k128), .M(m),
    .C(c128), .ack(ack128), .busy(busy128));

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [3:0] sb_inv(input logic [3:0] y);
    for (int v = 0; v < 16; v++) if (SBOX[v] == y) return 4'(v);
    return 4'h0;
  endfunction

  function automatic logic [63:0] sub(input logic [63:0] s, input bit inv);
    logic [63:0] t;
    for (int n = 0; n < 16; n++) t[4*n +: 4] = inv ? sb_inv(s[4*n +: 4]) : SBOX[s[4*n +: 4]];
    return t;
  endfunction

  function automatic logic [63:0] perm(input logic [63:0] s, input bit inv);
    logic [63:0] t;
    t[63] = s[63];
    for (int j = 0; j < 63; j++) begin
      if (inv) t[j] = s[(16 * j) % 63];
      else     t[(16 * j) % 63] = s[j];
    end
    return t;
  endfunction

  function automatic logic [127:0] next_key(input bit w, input logic [127:0] kr, input int i);
    logic [127:0] a;
    logic [79:0]  b;
    if (w) begin
      a = {kr[66:0], kr[127:67]};
      a[127:124] = SBOX[a[127:124]];
      a[123:120] = SBOX[a[123:120]];
      a[66:62]   = a[66:62] ^ 5'(i);
      return a;
    end
    b = kr[79:0];
    b = {b[18:0], b[79:19]};
    b[79:76] = SBOX[b[79:76]];
    b[19:15] = b[19:15] ^ 5'(i);
    return {48'h0, b};
  endfunction

  function automatic logic [63:0] ref_crypt(input bit w, input bit d, input logic [127:0] k,
                                            input logic [63:0] x);
    logic [63:0]  rks [33];
    logic [127:0] kr;
    logic [63:0]  s;
    kr = k;
    for (int i = 1; i <= R + 1; i++) begin
      rks[i] = w ? kr[127:64] : kr[79:16];
      if (i <= R) kr = next_key(w, kr, i);
    end
    if (!d) begin
      s = x;
      for (int i = 1; i <= R; i++) s = perm(sub(s ^ rks[i], 1'b0), 1'b0);
      return s ^ rks[R+1];
    end
    s = x ^ rks[R+1];
    for (int i = R; i >= 1; i--) s = sub(perm(s, 1'b1), 1'b1) ^ rks[i];
    return s;
  endfunction

  // Expected capture-to-ack latency; updates the cache model on a miss.
  function automatic int model_lat(input bit w, input bit d, input logic [127:0] k);
    if (!d) return R + 1;
    if (cv[w] && ck[w] == k) return R + 1;
    cv[w] = 1'b1;
    ck[w] = k;
    return 2 * R + 1;
  endfunction

  // ---------------- DUT access helpers ----------------
  function automatic logic get_ack(input bit w);
    return w ? ack128 : ack80;
  endfunction

  function automatic logic get_busy(input bit w);
    return w ? busy128 : busy80;
  endfunction

  function automatic logic [63:0] get_c(input bit w);
    return w ? c128 : c80;
  endfunction

  task automatic set_req(input bit w, input logic v);
    if (w) req128 = v;
    else   req80  = v;
  endtask

  function automatic logic [127:0] rand_key(input bit w);
    logic [127:0] k;
    k = {$urandom, $urandom, $urandom, $urandom};
    if (!w) k[127:80] = '0;
    return k;
  endfunction

  // One full four-phase transaction. Inputs are scrambled right after the
  // capture edge; req stays high until ack and is then dropped.
  task automatic do_op(input bit w, input bit d, input logic [127:0] k, input logic [63:0] mi,
                       input logic [63:0] exp_c, input int exp_lat, input string tag);
    int n;
    int bcnt;
    @(negedge clk);
    dec = d;
    m   = mi;
    if (w) k128 = k;
    else   k80  = k[79:0];
    set_req(w, 1'b1);
    @(posedge clk);
    n    = 0;
    bcnt = 0;
    @(negedge clk);
    dec  = ~d;
    m    = {$urandom, $urandom};
    k80  = {$urandom, $urandom, $urandom};
    k128 = {$urandom, $urandom, $urandom, $urandom};
    while (!get_ack(w) && n < LIMIT) begin
      if (get_busy(w)) bcnt++;
      n++;
      @(negedge clk);
    end
    n_checks++;
    if (!get_ack(w)) begin
      n_fail++;
      $display("FAIL %s timeout: ack=0 after %0d cycles, required 1 by %0d", tag, n, exp_lat);
      set_req(w, 1'b0);
      return;
    end
    n_checks++;
    if (get_c(w) !== exp_c) begin
      n_fail++;
      $display("FAIL %s result: C=%h, required %h", tag, get_c(w), exp_c);
    end
    n_checks++;
    if (n !== exp_lat) begin
      n_fail++;
      $display("FAIL %s latency: ack after %0d cycles, required %0d", tag, n, exp_lat);
    end
    n_checks++;
    if (bcnt !== exp_lat - 1 || get_busy(w) !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy: high %0d cycles (busy at ack=%b), required %0d and 0",
               tag, bcnt, get_busy(w), exp_lat - 1);
    end
    set_req(w, 1'b0);
    @(negedge clk);
    n_checks++;
    if (get_ack(w) !== 1'b0) begin
      n_fail++;
      $display("FAIL %s ack_drop: ack=%b one edge after req low, required 0", tag, get_ack(w));
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    req80 = 1'b0; req128 = 1'b0; dec = 1'b0;
    k80 = '0; k128 = '0; m = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (c80 !== 64'h0 || ack80 !== 1'b0 || busy80 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset80: C=%h ack=%b busy=%b, required 0 0 0", c80, ack80, busy80);
    end
    n_checks++;
    if (c128 !== 64'h0 || ack128 !== 1'b0 || busy128 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset128: C=%h ack=%b busy=%b, required 0 0 0", c128, ack128, busy128);
    end
    rst_n = 1'b1;
    cv[0] = 1'b0; cv[1] = 1'b0;
  endtask

  task automatic test_vectors_80;
    logic [127:0] ones;
    ones = {48'h0, {80{1'b1}}};
    do_op(0, 0, 128'h0, 64'h0, 64'h5579C1387B228445, model_lat(0, 0, 128'h0), "enc80_zero");
    do_op(0, 0, ones, '1, 64'h3333DCD3213210D2, model_lat(0, 0, ones), "enc80_ones");
    do_op(0, 1, ones, 64'h3333DCD3213210D2, '1, model_lat(0, 1, ones), "dec80_miss");
    do_op(0, 1, ones, 64'h3333DCD3213210D2, '1, model_lat(0, 1, ones), "dec80_hit");
    do_op(0, 1, 128'h0, 64'h5579C1387B228445, 64'h0, model_lat(0, 1, 128'h0), "dec80_newkey");
  endtask

  task automatic test_vectors_128;
    do_op(1, 0, 128'h0, 64'h0, 64'h96DB702A2E6900AF, model_lat(1, 0, 128'h0), "enc128_zero");
    do_op(1, 1, 128'h0, 64'h96DB702A2E6900AF, 64'h0, model_lat(1, 1, 128'h0), "dec128_zero");
  endtask

  task automatic test_random;
    logic [127:0] last_k [2];
    last_k[0] = rand_key(0);
    last_k[1] = rand_key(1);
    for (int it = 0; it < 14; it++) begin
      bit           w, d;
      logic [127:0] k;
      logic [63:0]  x;
      w = 1'($urandom_range(0, 1));
      d = ($urandom_range(0, 3) != 0);
      k = ($urandom_range(0, 1) == 0) ? last_k[w] : rand_key(w);
      last_k[w] = k;
      x = {$urandom, $urandom};
      do_op(w, d, k, x, ref_crypt(w, d, k, x), model_lat(w, d, k), "random");
    end
  endtask

  task automatic test_handshake;
    logic [127:0] k;
    logic [63:0]  x, exp_c;
    int           n, bad;
    // req dropped mid-RUN: operation completes, ack is a one-cycle pulse.
    k = rand_key(0);
    x = {$urandom, $urandom};
    exp_c = ref_crypt(0, 0, k, x);
    @(negedge clk);
    dec = 1'b0; m = x; k80 = k[79:0]; req80 = 1'b1;
    @(posedge clk);
    repeat (5) @(negedge clk);
    req80 = 1'b0;
    n = 0;
    while (ack80 !== 1'b1 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (ack80 !== 1'b1 || c80 !== exp_c) begin
      n_fail++;
      $display("FAIL drop_req_complete: ack=%b C=%h, required 1 %h", ack80, c80, exp_c);
    end
    @(negedge clk);
    n_checks++;
    if (ack80 !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_req_pulse: ack=%b one cycle later, required 0", ack80);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (ack80 !== 1'b0 || busy80 !== 1'b0 || c80 !== exp_c) begin
      n_fail++;
      $display("FAIL idle_hold: ack=%b busy=%b C=%h, required 0 0 %h", ack80, busy80, c80, exp_c);
    end

    // req held after ack: ack stays high, no restart.
    k = rand_key(0);
    x = {$urandom, $urandom};
    exp_c = ref_crypt(0, 0, k, x);
    @(negedge clk);
    dec = 1'b0; m = x; k80 = k[79:0]; req80 = 1'b1;
    @(posedge clk);
    n = 0;
    while (ack80 !== 1'b1 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack80 !== 1'b1 || busy80 !== 1'b0 || c80 !== exp_c) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL hold_req: %0d bad cycles (ack=%b busy=%b C=%h), required 0", bad, ack80, busy80, c80);
    end
    req80 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ack80 !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_release: ack=%b, required 0", ack80);
    end
    k = rand_key(0);
    x = {$urandom, $urandom};
    do_op(0, 0, k, x, ref_crypt(0, 0, k, x), model_lat(0, 0, k), "restart");
  endtask

  task automatic test_reset_midrun;
    logic [127:0] kx;
    logic [63:0]  cx;
    kx = rand_key(0);
    cx = {$urandom, $urandom};
    do_op(0, 1, kx, cx, ref_crypt(0, 1, kx, cx), model_lat(0, 1, kx), "prime_dec");
    @(negedge clk);
    dec = 1'b0; m = {$urandom, $urandom}; k80 = rand_key(0); req80 = 1'b1;
    @(posedge clk);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ack80 !== 1'b0 || busy80 !== 1'b0 || c80 !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_midrun: ack=%b busy=%b C=%h, required 0 0 0", ack80, busy80, c80);
    end
    n_checks++;
    if (c128 !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_midrun128: C=%h, required 0", c128);
    end
    rst_n = 1'b1;
    req80 = 1'b0;
    cv[0] = 1'b0; cv[1] = 1'b0;
    do_op(0, 1, kx, cx, ref_crypt(0, 1, kx, cx), model_lat(0, 1, kx), "post_reset_dec");
  endtask

  initial begin
    test_reset;
    test_vectors_80;
    test_vectors_128;
    test_random;
    test_handshake;
    test_reset_midrun;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
